alu_multicycle: RTL

//  Parametrised successor to the single-cycle datapath ALU. Registered logic/shift ops complete in 1 cycle.

---
 rtl/alu_multicycle.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_multicycle.sv
// Multi-cycle EX-stage ALU: registered one-cycle logic/shift/arith ops plus
// iterative shift-add multiply and restoring divide behind a Start/Busy/Done handshake.
module alu_multicycle #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [3:0]       ALUControl,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Result,
   output logic [WIDTH-1:0] Hi,
   output logic             Zero,
   output logic             Busy,
   output logic             Done,
   output logic             DivByZero
);

   localparam logic [3:0] OP_AND   = 4'd0;
   localparam logic [3:0] OP_OR    = 4'd1;
   localparam logic [3:0] OP_ADD   = 4'd2;
   localparam logic [3:0] OP_NOR   = 4'd3;
   localparam logic [3:0] OP_XOR   = 4'd4;
   localparam logic [3:0] OP_DIV   = 4'd5;
   localparam logic [3:0] OP_SUB   = 4'd6;
   localparam logic [3:0] OP_SLT   = 4'd7;
   localparam logic [3:0] OP_MULTU = 4'd8;
   localparam logic [3:0] OP_MUL   = 4'd9;
   localparam logic [3:0] OP_SLL   = 4'd10;
   localparam logic [3:0] OP_DIVU  = 4'd12;
   localparam logic [3:0] OP_SRL   = 4'd13;
   localparam logic [3:0] OP_SLTU  = 4'd14;
   localparam logic [3:0] OP_SRA   = 4'd15;

   localparam logic [SHAMT_W-1:0] LAST_STEP = SHAMT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t               state_r;
   logic                 is_div_r;
   logic                 neg_q_r;
   logic                 neg_r_r;
   logic                 dbz_r;
   logic [WIDTH-1:0]     a_orig_r;
   logic [WIDTH-1:0]     hi_r;
   logic [WIDTH-1:0]     lo_r;
   logic [WIDTH-1:0]     dsr_r;
   logic [SHAMT_W-1:0]   cnt_r;

   logic [WIDTH-1:0]     alu_res_s;
   logic                 is_iter_s;
   logic                 is_div_s;
   logic                 is_signed_s;
   logic                 a_neg_s;
   logic                 b_neg_s;
   logic [WIDTH-1:0]     a_mag_s;
   logic [WIDTH-1:0]     b_mag_s;
   logic [SHAMT_W-1:0]   shamt_s;
   logic [WIDTH:0]       mul_sum_s;
   logic [WIDTH:0]       div_sh_s;
   logic [WIDTH:0]       div_diff_s;
   logic [WIDTH-1:0]     next_hi_s;
   logic [WIDTH-1:0]     next_lo_s;
   logic [2*WIDTH-1:0]   prod_s;
   logic [WIDTH-1:0]     fix_res_s;
   logic [WIDTH-1:0]     fix_hi_s;

   // One-cycle result and operand decode for iterative launch
   always_comb begin
      shamt_s     = B[SHAMT_W-1:0];
      is_signed_s = (ALUControl == OP_MUL) || (ALUControl == OP_DIV);
      is_div_s    = (ALUControl == OP_DIV) || (ALUControl == OP_DIVU);
      is_iter_s   = is_div_s || (ALUControl == OP_MUL) || (ALUControl == OP_MULTU);
      a_neg_s     = is_signed_s & A[WIDTH-1];
      b_neg_s     = is_signed_s & B[WIDTH-1];
      a_mag_s     = a_neg_s ? (WIDTH'(0) - A) : A;
      b_mag_s     = b_neg_s ? (WIDTH'(0) - B) : B;
      case (ALUControl)
         OP_AND:  alu_res_s = A & B;
         OP_OR:   alu_res_s = A | B;
         OP_ADD:  alu_res_s = A + B;
         OP_NOR:  alu_res_s = ~(A | B);
         OP_XOR:  alu_res_s = A ^ B;
         OP_SUB:  alu_res_s = A - B;
         OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (A < B)};
         OP_SLL:  alu_res_s = A << shamt_s;
         OP_SRL:  alu_res_s = A >> shamt_s;
         OP_SRA:  alu_res_s = WIDTH'($signed(A) >>> shamt_s);
         default: alu_res_s = {WIDTH{1'b0}};
      endcase
   end

   // One iteration step: shift-add for multiply, shift-subtract-restore for divide
   always_comb begin
      mul_sum_s  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, dsr_r} : {(WIDTH+1){1'b0}});
      div_sh_s   = {hi_r, lo_r[WIDTH-1]};
      div_diff_s = div_sh_s - {1'b0, dsr_r};
      if (is_div_r) begin
         if (!div_diff_s[WIDTH]) begin
            next_hi_s = div_diff_s[WIDTH-1:0];
            next_lo_s = {lo_r[WIDTH-2:0], 1'b1};
         end else begin
            next_hi_s = div_sh_s[WIDTH-1:0];
            next_lo_s = {lo_r[WIDTH-2:0], 1'b0};
         end
      end else begin
         next_hi_s = mul_sum_s[WIDTH:1];
         next_lo_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
      end
   end

   // Sign correction of the magnitude result; divide-by-zero overrides everything
   always_comb begin
      prod_s = neg_q_r ? ((2*WIDTH)'(0) - {hi_r, lo_r}) : {hi_r, lo_r};
      if (!is_div_r) begin
         fix_res_s = prod_s[WIDTH-1:0];
         fix_hi_s  = prod_s[2*WIDTH-1:WIDTH];
      end else if (dbz_r) begin
         fix_res_s = {WIDTH{1'b1}};
         fix_hi_s  = a_orig_r;
      end else begin
         fix_res_s = neg_q_r ? (WIDTH'(0) - lo_r) : lo_r;
         fix_hi_s  = neg_r_r ? (WIDTH'(0) - hi_r) : hi_r;
      end
   end

   // Control FSM with registered outputs
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_r   <= IDLE;
         Result    <= {WIDTH{1'b0}};
         Hi        <= {WIDTH{1'b0}};
         Zero      <= 1'b1;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         DivByZero <= 1'b0;
         is_div_r  <= 1'b0;
         neg_q_r   <= 1'b0;
         neg_r_r   <= 1'b0;
         dbz_r     <= 1'b0;
         a_orig_r  <= {WIDTH{1'b0}};
         hi_r      <= {WIDTH{1'b0}};
         lo_r      <= {WIDTH{1'b0}};
         dsr_r     <= {WIDTH{1'b0}};
         cnt_r     <= {SHAMT_W{1'b0}};
      end else begin
         Done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (Start && is_iter_s) begin
                  is_div_r <= is_div_s;
                  neg_q_r  <= a_neg_s ^ b_neg_s;
                  neg_r_r  <= a_neg_s;
                  dbz_r    <= is_div_s && (B == {WIDTH{1'b0}});
                  a_orig_r <= A;
                  hi_r     <= {WIDTH{1'b0}};
                  lo_r     <= a_mag_s;
                  dsr_r    <= b_mag_s;
                  cnt_r    <= {SHAMT_W{1'b0}};
                  Busy     <= 1'b1;
                  state_r  <= ITER;
               end else if (Start) begin
                  Result    <= alu_res_s;
                  Hi        <= {WIDTH{1'b0}};
                  Zero      <= (alu_res_s == {WIDTH{1'b0}});
                  DivByZero <= 1'b0;
                  Done      <= 1'b1;
               end
            end
            ITER: begin
               hi_r  <= next_hi_s;
               lo_r  <= next_lo_s;
               cnt_r <= cnt_r + SHAMT_W'(1);
               if (cnt_r == LAST_STEP) begin
                  state_r <= FIX;
               end
            end
            FIX: begin
               Result    <= fix_res_s;
               Hi        <= fix_hi_s;
               Zero      <= (fix_res_s == {WIDTH{1'b0}});
               DivByZero <= dbz_r;
               Done      <= 1'b1;
               Busy      <= 1'b0;
               state_r   <= IDLE;
            end
            default: begin
               Busy    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule
